oqpsk_bit_packer: RTL

Receive-side counterpart of the transmit-side I/Q bit splitter: takes hard-decision inphase and quadrature bit streams from the OQPSK demodulator and re-interleaves them into AXI-Stream master words. Each word uses the transmit bit layout: quadrature bit of pair j at tdata[2j], inphase bit at tdata[2j+1]. The block sits between the symbol-decision stage and the DMA/AXIS output. It frames packets of a fixed word count with tlast and buffers one word against backpressure.

---
 rtl/oqpsk_bit_packer_if.sv | 24 ++
 rtl/oqpsk_bit_packer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/oqpsk_bit_packer_if.sv
// AXI-Stream style word bus used by the OQPSK bit packer.
// master drives tdata/tvalid/tlast, slave drives tready.
interface oqpsk_bit_packer_if #(
  parameter int WIDTH = 64
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/oqpsk_bit_packer.sv
// Re-interleaves demodulated I/Q bit streams into AXIS words:
// Q of pair j at tdata[2j], I at tdata[2j+1], tlast every
// PACKET_WORDS words, one output word of buffering.
// Ports: aclk, sreset (sync, active high), I/Q bits + valids,
// m00_axis (master bus), sticky pairing/overflow error flags.
module oqpsk_bit_packer #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int PACKET_WORDS           = 4
) (
  input  logic aclk,
  input  logic sreset,
  input  logic inphase_bit,
  input  logic inphase_bit_valid,
  input  logic quadrature_bit,
  input  logic quadrature_bit_valid,
  oqpsk_bit_packer_if.master m00_axis,
  output logic pairing_error,
  output logic overflow_error
);

  localparam int W     = C_M00_AXIS_TDATA_WIDTH;
  localparam int PAIRS = W / 2;
  localparam int PCW   = $clog2(PAIRS);
  localparam int WCW   =
    (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;

  localparam logic [PCW-1:0] P_LAST = PCW'(PAIRS - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(PACKET_WORDS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  ostate_t state;
  ostate_t state_nxt;

  logic           pend;
  logic           pend_bit;
  logic           pend_nxt;
  logic           pend_bit_nxt;
  logic           fire;
  logic           pair_i;
  logic           pair_q;
  logic           pair_err;

  logic [PCW-1:0] pair_cnt;
  logic [WCW-1:0] word_cnt;
  logic [W-1:0]   acc;
  logic [W-1:0]   word;

  logic           last_pair;
  logic           take;
  logic           load;
  logic           drop;

  logic [W-1:0]   tdata_q;
  logic           tlast_q;

  // Pairing: the four valid/pending combinations are
  // mutually exclusive; idle cycles fall to the default.
  always_comb begin
    fire         = 1'b0;
    pair_i       = pend_bit;
    pair_q       = quadrature_bit;
    pend_nxt     = pend;
    pend_bit_nxt = pend_bit;
    pair_err     = 1'b0;
    unique case (1'b1)
      quadrature_bit_valid && pend: begin
        fire   = 1'b1;
        pair_i = pend_bit;
        if (inphase_bit_valid) begin
          pend_bit_nxt = inphase_bit;
        end else begin
          pend_nxt = 1'b0;
        end
      end
      quadrature_bit_valid && inphase_bit_valid
        && !pend: begin
        fire   = 1'b1;
        pair_i = inphase_bit;
      end
      quadrature_bit_valid && !inphase_bit_valid
        && !pend: begin
        pair_err = 1'b1;
      end
      inphase_bit_valid && !quadrature_bit_valid: begin
        pend_nxt     = 1'b1;
        pend_bit_nxt = inphase_bit;
        pair_err     = pend;
      end
      default: ;
    endcase
  end

  // Current word with this cycle's pair merged in, so the
  // final pair lands in the loaded output word directly.
  always_comb begin
    word = acc;
    if (fire) begin
      word[{pair_cnt, 1'b0}] = pair_q;
      word[{pair_cnt, 1'b1}] = pair_i;
    end
  end

  assign last_pair = fire && (pair_cnt == P_LAST);
  assign take      = m00_axis.tvalid && m00_axis.tready;
  assign load      = last_pair && ((state == EMPTY) || take);
  assign drop      = last_pair && !load;

  // Stale acc bits are always overwritten before a word
  // completes, so acc needs no reset.
  always_ff @(posedge aclk) begin
    if (fire) begin
      acc <= word;
    end
  end

  always_ff @(posedge aclk) begin
    if (sreset) begin
      pend     <= 1'b0;
      pend_bit <= 1'b0;
      pair_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_bit <= pend_bit_nxt;
      if (fire) begin
        if (pair_cnt == P_LAST) begin
          pair_cnt <= '0;
        end else begin
          pair_cnt <= pair_cnt + 1'b1;
        end
      end
    end
  end

  // Dropped words still advance word_cnt to keep framing.
  always_ff @(posedge aclk) begin
    if (sreset) begin
      word_cnt <= '0;
    end else if (last_pair) begin
      if (word_cnt == W_LAST) begin
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (sreset) begin
      tdata_q <= '0;
      tlast_q <= 1'b0;
    end else if (load) begin
      tdata_q <= word;
      tlast_q <= (word_cnt == W_LAST);
    end
  end

  always_ff @(posedge aclk) begin
    if (sreset) begin
      pairing_error  <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      if (pair_err) begin
        pairing_error <= 1'b1;
      end
      if (drop) begin
        overflow_error <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (sreset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (load) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (m00_axis.tready && !load) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    m00_axis.tvalid = (state == FULL);
    m00_axis.tdata  = tdata_q;
    m00_axis.tlast  = tlast_q;
  end

endmodule
